// File: rtl/mem_arbiter_if.sv
// Bundle of the CPU-side and memory-side signals around mem_arbiter.
// The master modport is the arbiter's view: it masters the memory and answers
// the two CPU ports. The slave modport is the view of the surrounding system.
interface mem_arbiter_if;
  // instruction-fetch port
  logic        i_req;
  logic [15:0] i_addr;
  logic [15:0] i_rdata;
  logic        i_ack;
  // load/store data port
  logic        d_req;
  logic        d_we;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic [15:0] d_rdata;
  logic        d_ack;
  logic        bus_err;
  // single-port main memory
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ready;

  modport master (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    output i_rdata, i_ack, d_rdata, d_ack, bus_err,
           mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    input  i_rdata, i_ack, d_rdata, d_ack, bus_err,
           mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one single-port 16-bit memory between instruction fetch and the
// load/store port. Data normally wins a tie, but after STARVE_MAX consecutive
// data grants with a fetch waiting, the fetch is served. Accesses that see no
// mem_ready within TIMEOUT cycles are aborted with bus_err and rdata 16'hFFFF.
// Every output comes straight from a register.
module mem_arbiter #(
  parameter int STARVE_MAX = 4,   // 1..255
  parameter int TIMEOUT    = 16   // 2..255
) (
  input logic           clock,
  input logic           reset,    // asynchronous, active low
  mem_arbiter_if.master bus
);

  localparam logic [7:0] STARVE_LIM   = 8'(STARVE_MAX);
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_t;

  state_t      state_reg,      state_next;
  logic [7:0]  starve_cnt_reg, starve_cnt_next;
  logic [7:0]  wait_cnt_reg,   wait_cnt_next;
  logic [15:0] addr_reg,       addr_next;
  logic [15:0] wdata_reg,      wdata_next;
  logic        we_reg,         we_next;
  logic        mem_req_reg,    mem_req_next;
  logic [15:0] i_rdata_reg,    i_rdata_next;
  logic [15:0] d_rdata_reg,    d_rdata_next;
  logic        i_ack_reg,      i_ack_next;
  logic        d_ack_reg,      d_ack_next;
  logic        bus_err_reg,    bus_err_next;

  logic grant_i;
  logic grant_d;

  // Arbitration: a lone request wins; on a tie data wins until the fetch has
  // been passed over STARVE_MAX times in a row.
  always_comb begin
    grant_i = bus.i_req && (!bus.d_req || (starve_cnt_reg == STARVE_LIM));
    grant_d = bus.d_req && !grant_i;
  end

  // Next-state and next-output logic of the access sequencer.
  always_comb begin
    state_next      = state_reg;
    starve_cnt_next = starve_cnt_reg;
    wait_cnt_next   = wait_cnt_reg;
    addr_next       = addr_reg;
    wdata_next      = wdata_reg;
    we_next         = we_reg;
    mem_req_next    = mem_req_reg;
    i_rdata_next    = i_rdata_reg;
    d_rdata_next    = d_rdata_reg;
    i_ack_next      = 1'b0;
    d_ack_next      = 1'b0;
    bus_err_next    = 1'b0;

    case (state_reg)
      IDLE: begin
        if (grant_i) begin
          state_next      = BUSY_I;
          starve_cnt_next = 8'd0;
          wait_cnt_next   = 8'd0;
          addr_next       = bus.i_addr;
          we_next         = 1'b0;
          mem_req_next    = 1'b1;
        end else if (grant_d) begin
          state_next    = BUSY_D;
          wait_cnt_next = 8'd0;
          addr_next     = bus.d_addr;
          wdata_next    = bus.d_wdata;
          we_next       = bus.d_we;
          mem_req_next  = 1'b1;
          // Only a data grant that overtakes a waiting fetch counts.
          if (bus.i_req && (starve_cnt_reg != STARVE_LIM)) begin
            starve_cnt_next = starve_cnt_reg + 8'd1;
          end
        end
      end

      BUSY_I, BUSY_D: begin
        if (!bus.mem_ready) begin
          wait_cnt_next = wait_cnt_reg + 8'd1;
        end
        // A late mem_ready still beats the timeout in the same cycle.
        if (bus.mem_ready || (wait_cnt_reg == TIMEOUT_LAST)) begin
          state_next   = DONE;
          mem_req_next = 1'b0;
          we_next      = 1'b0;
          bus_err_next = !bus.mem_ready;
          if (state_reg == BUSY_I) begin
            i_ack_next   = 1'b1;
            i_rdata_next = bus.mem_ready ? bus.mem_rdata : 16'hFFFF;
          end else begin
            d_ack_next   = 1'b1;
            d_rdata_next = bus.mem_ready ? bus.mem_rdata : 16'hFFFF;
          end
        end
      end

      DONE: begin
        // The ack cycle: requests are ignored until back in IDLE.
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any access at once.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      starve_cnt_reg <= 8'd0;
      wait_cnt_reg   <= 8'd0;
      addr_reg       <= 16'd0;
      wdata_reg      <= 16'd0;
      we_reg         <= 1'b0;
      mem_req_reg    <= 1'b0;
      i_rdata_reg    <= 16'd0;
      d_rdata_reg    <= 16'd0;
      i_ack_reg      <= 1'b0;
      d_ack_reg      <= 1'b0;
      bus_err_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      starve_cnt_reg <= starve_cnt_next;
      wait_cnt_reg   <= wait_cnt_next;
      addr_reg       <= addr_next;
      wdata_reg      <= wdata_next;
      we_reg         <= we_next;
      mem_req_reg    <= mem_req_next;
      i_rdata_reg    <= i_rdata_next;
      d_rdata_reg    <= d_rdata_next;
      i_ack_reg      <= i_ack_next;
      d_ack_reg      <= d_ack_next;
      bus_err_reg    <= bus_err_next;
    end
  end

  assign bus.mem_req   = mem_req_reg;
  assign bus.mem_we    = we_reg;
  assign bus.mem_addr  = addr_reg;
  assign bus.mem_wdata = wdata_reg;
  assign bus.i_rdata   = i_rdata_reg;
  assign bus.d_rdata   = d_rdata_reg;
  assign bus.i_ack     = i_ack_reg;
  assign bus.d_ack     = d_ack_reg;
  assign bus.bus_err   = bus_err_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with STARVE_MAX=2 and TIMEOUT=4.
// A memory model answers after a programmable delay; every expected ack is
// queued when its request is driven and checked when the ack appears.
module tb_mem_arbiter;
  localparam int STARVE_MAX = 2;
  localparam int TIMEOUT    = 4;

  typedef struct {
    bit          is_i;
    logic [15:0] rdata;
    bit          chk_data;
    bit          err;
    int          id;
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  int   mem_delay = 0;   // BUSY cycles before mem_ready; negative = never
  exp_t sb[$];

  mem_arbiter_if bus ();

  mem_arbiter #(.STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  function automatic logic [15:0] mem_value(input logic [15:0] addr);
    return (addr == 16'h0040) ? 16'hA5A5 : (addr ^ 16'h3C3C);
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Memory model: drives mem_ready/mem_rdata mid-cycle.
  task automatic run_memory();
    int busy_cnt = 0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 16'hDEAD;
    forever begin
      @(negedge clock);
      if (bus.mem_req === 1'b1) begin
        if (mem_delay >= 0 && busy_cnt >= mem_delay) begin
          bus.mem_ready = 1'b1;
          bus.mem_rdata = bus.mem_we ? 16'h0000 : mem_value(bus.mem_addr);
        end else begin
          bus.mem_ready = 1'b0;
          bus.mem_rdata = 16'hDEAD;
        end
        busy_cnt++;
      end else begin
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 16'hDEAD;
        busy_cnt = 0;
      end
    end
  endtask

  // Scoreboard monitor: pops one expectation per observed ack.
  task automatic run_monitor();
    exp_t        e;
    logic [15:0] got;
    forever begin
      @(negedge clock);
      if (bus.i_ack || bus.d_ack) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected_ack: i_ack=%0b d_ack=%0b, required no ack", bus.i_ack, bus.d_ack);
        end else begin
          e = sb.pop_front();
          got = e.is_i ? bus.i_rdata : bus.d_rdata;
          $display("TXN id=%0d port=%s rdata=%h bus_err=%0b", e.id, bus.i_ack ? "I" : "D", got, bus.bus_err);
          checks++;
          if ({bus.i_ack, bus.d_ack} !== (e.is_i ? 2'b10 : 2'b01)) begin
            failures++;
            $display("FAIL sb_port id=%0d: acks(i,d)=%b, required %b", e.id, {bus.i_ack, bus.d_ack}, e.is_i ? 2'b10 : 2'b01);
          end
          if (e.chk_data) begin
            checks++;
            if (got !== e.rdata) begin
              failures++;
              $display("FAIL sb_rdata id=%0d: got %h, required %h", e.id, got, e.rdata);
            end
          end
          checks++;
          if (bus.bus_err !== e.err) begin
            failures++;
            $display("FAIL sb_bus_err id=%0d: got %0b, required %0b", e.id, bus.bus_err, e.err);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) step();
    checks++;
    if ({bus.mem_req, bus.mem_we, bus.i_ack, bus.d_ack, bus.bus_err} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b, required 00000", {bus.mem_req, bus.mem_we, bus.i_ack, bus.d_ack, bus.bus_err});
    end
    checks++;
    if ({bus.mem_addr, bus.mem_wdata, bus.i_rdata, bus.d_rdata} !== 64'h0) begin
      failures++;
      $display("FAIL reset_data: got %h, required 0", {bus.mem_addr, bus.mem_wdata, bus.i_rdata, bus.d_rdata});
    end
    reset = 1'b1;
    repeat (2) step();
    checks++;
    if (bus.mem_req !== 1'b0) begin
      failures++;
      $display("FAIL idle_no_req: mem_req=%0b, required 0", bus.mem_req);
    end
  endtask

  task automatic test_single_fetch();
    int lat = 0;
    bit seen = 0;
    bit bad_bus = 0;
    mem_delay = 0;
    bus.i_req  = 1'b1;
    bus.i_addr = 16'h0040;
    sb.push_back('{is_i:1'b1, rdata:16'hA5A5, chk_data:1'b1, err:1'b0, id:1});
    for (int c = 0; c < 20 && !seen; c++) begin
      step();
      lat++;
      if (bus.mem_req && (bus.mem_addr !== 16'h0040 || bus.mem_we !== 1'b0)) bad_bus = 1;
      if (bus.i_ack) begin
        seen = 1;
        bus.i_req = 1'b0;
      end
    end
    checks++;
    if (!seen || lat != 2) begin
      failures++;
      $display("FAIL fetch_latency: seen=%0b edges=%0d, required seen=1 edges=2", seen, lat);
    end
    checks++;
    if (bad_bus) begin
      failures++;
      $display("FAIL fetch_mem_bus: addr/we wrong, required addr=0040 we=0");
    end
    step();
    checks++;
    if (bus.i_ack !== 1'b0) begin
      failures++;
      $display("FAIL fetch_ack_width: i_ack=%0b one cycle later, required 0", bus.i_ack);
    end
  endtask

  task automatic test_store();
    int  hi = 0;
    bit  seen = 0;
    bit  bad_bus = 0;
    mem_delay = 2;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 16'h1234;
    bus.d_wdata = 16'hBEEF;
    sb.push_back('{is_i:1'b0, rdata:16'h0000, chk_data:1'b0, err:1'b0, id:2});
    for (int c = 0; c < 20 && !seen; c++) begin
      step();
      if (bus.mem_req) begin
        hi++;
        if (bus.mem_we !== 1'b1 || bus.mem_addr !== 16'h1234 || bus.mem_wdata !== 16'hBEEF) bad_bus = 1;
      end
      if (bus.d_ack) begin
        seen = 1;
        bus.d_req = 1'b0;
        bus.d_we  = 1'b0;
      end
    end
    checks++;
    if (!seen || bad_bus) begin
      failures++;
      $display("FAIL store_bus: seen=%0b unstable=%0b, required seen=1 unstable=0", seen, bad_bus);
    end
    checks++;
    if (hi != 3) begin
      failures++;
      $display("FAIL store_busy_cycles: got %0d, required 3", hi);
    end
    step();
    checks++;
    if (bus.d_ack !== 1'b0) begin
      failures++;
      $display("FAIL store_ack_width: d_ack=%0b, required 0", bus.d_ack);
    end
  endtask

  task automatic test_simultaneous();
    int cyc = 0;
    int d_cyc = -1;
    int i_cyc = -1;
    mem_delay = 0;
    bus.i_req  = 1'b1;
    bus.i_addr = 16'h0200;
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 16'h0100;
    sb.push_back('{is_i:1'b0, rdata:mem_value(16'h0100), chk_data:1'b1, err:1'b0, id:3});
    sb.push_back('{is_i:1'b1, rdata:mem_value(16'h0200), chk_data:1'b1, err:1'b0, id:4});
    for (int c = 0; c < 30 && (d_cyc < 0 || i_cyc < 0); c++) begin
      step();
      cyc++;
      if (bus.d_ack) begin
        d_cyc = cyc;
        bus.d_req = 1'b0;
      end
      if (bus.i_ack) begin
        i_cyc = cyc;
        bus.i_req = 1'b0;
      end
    end
    checks++;
    if (d_cyc < 0 || i_cyc < 0 || d_cyc >= i_cyc) begin
      failures++;
      $display("FAIL simul_order: d_ack edge=%0d i_ack edge=%0d, required d before i", d_cyc, i_cyc);
    end
    step();
    checks++;
    if (bus.d_rdata !== mem_value(16'h0100)) begin
      failures++;
      $display("FAIL d_rdata_hold: got %h, required %h", bus.d_rdata, mem_value(16'h0100));
    end
  endtask

  task automatic test_starvation();
    int got[6];
    int want[6];
    int n = 0;
    want = '{0, 0, 1, 0, 0, 1};
    mem_delay = 0;
    bus.i_req  = 1'b1;
    bus.i_addr = 16'h0301;
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 16'h0300;
    for (int k = 0; k < 6; k++) begin
      sb.push_back('{is_i:(want[k] == 1), rdata:mem_value(want[k] == 1 ? 16'h0301 : 16'h0300),
                     chk_data:1'b1, err:1'b0, id:10 + k});
    end
    for (int c = 0; c < 80 && n < 6; c++) begin
      step();
      if (bus.i_ack || bus.d_ack) begin
        got[n] = bus.i_ack ? 1 : 0;
        n++;
      end
    end
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    checks++;
    if (n != 6) begin
      failures++;
      $display("FAIL starve_count: got %0d acks, required 6", n);
    end
    for (int k = 0; k < n; k++) begin
      checks++;
      if (got[k] != want[k]) begin
        failures++;
        $display("FAIL starve_order[%0d]: got %s, required %s", k, got[k] == 1 ? "I" : "D", want[k] == 1 ? "I" : "D");
      end
    end
    repeat (2) step();
  endtask

  task automatic test_timeout();
    int hi = 0;
    bit seen = 0;
    mem_delay = -1;
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 16'h0400;
    sb.push_back('{is_i:1'b0, rdata:16'hFFFF, chk_data:1'b1, err:1'b1, id:20});
    for (int c = 0; c < 30 && !seen; c++) begin
      step();
      if (bus.mem_req) hi++;
      if (bus.d_ack) begin
        seen = 1;
        bus.d_req = 1'b0;
        checks++;
        if ({bus.mem_req, bus.bus_err, bus.d_rdata} !== {1'b0, 1'b1, 16'hFFFF}) begin
          failures++;
          $display("FAIL timeout_ack: mem_req=%0b bus_err=%0b d_rdata=%h, required 0 1 ffff",
                   bus.mem_req, bus.bus_err, bus.d_rdata);
        end
      end
    end
    checks++;
    if (!seen || hi != TIMEOUT) begin
      failures++;
      $display("FAIL timeout_len: seen=%0b mem_req cycles=%0d, required seen=1 cycles=%0d", seen, hi, TIMEOUT);
    end
    step();
    // mem_ready arriving in the timeout cycle must win.
    hi = 0;
    seen = 0;
    mem_delay = TIMEOUT - 1;
    bus.i_req  = 1'b1;
    bus.i_addr = 16'h0040;
    sb.push_back('{is_i:1'b1, rdata:16'hA5A5, chk_data:1'b1, err:1'b0, id:21});
    for (int c = 0; c < 30 && !seen; c++) begin
      step();
      if (bus.mem_req) hi++;
      if (bus.i_ack) begin
        seen = 1;
        bus.i_req = 1'b0;
      end
    end
    checks++;
    if (!seen || hi != TIMEOUT) begin
      failures++;
      $display("FAIL ready_at_timeout: seen=%0b mem_req cycles=%0d, required seen=1 cycles=%0d", seen, hi, TIMEOUT);
    end
    step();
  endtask

  task automatic test_reset_mid_access();
    int lat = 0;
    bit seen = 0;
    mem_delay = -1;
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 16'h0500;
    step();
    checks++;
    if (bus.mem_req !== 1'b1) begin
      failures++;
      $display("FAIL rst_busy: mem_req=%0b, required 1", bus.mem_req);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (bus.mem_req !== 1'b0) begin
      failures++;
      $display("FAIL rst_async: mem_req=%0b right after reset, required 0", bus.mem_req);
    end
    bus.d_req = 1'b0;
    repeat (2) step();
    checks++;
    if ({bus.i_ack, bus.d_ack, bus.mem_req} !== 3'b000) begin
      failures++;
      $display("FAIL rst_no_ack: acks/mem_req=%b, required 000", {bus.i_ack, bus.d_ack, bus.mem_req});
    end
    reset = 1'b1;
    step();
    mem_delay  = 0;
    bus.i_req  = 1'b1;
    bus.i_addr = 16'h0040;
    sb.push_back('{is_i:1'b1, rdata:16'hA5A5, chk_data:1'b1, err:1'b0, id:30});
    for (int c = 0; c < 20 && !seen; c++) begin
      step();
      lat++;
      if (bus.i_ack) begin
        seen = 1;
        bus.i_req = 1'b0;
      end
    end
    checks++;
    if (!seen || lat != 2) begin
      failures++;
      $display("FAIL rst_recover: seen=%0b edges=%0d, required seen=1 edges=2", seen, lat);
    end
  endtask

  initial begin
    reset       = 1'b0;
    bus.i_req   = 1'b0;
    bus.i_addr  = 16'h0000;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = 16'h0000;
    bus.d_wdata = 16'h0000;
    fork
      run_memory();
      run_monitor();
    join_none

    test_reset();
    test_single_fetch();
    test_store();
    test_simultaneous();
    test_starvation();
    test_timeout();
    test_reset_mid_access();

    repeat (3) step();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_pending: %0d expected acks never seen, required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
